regfile_write_arbiter: RTL and testbench

- Owns the single write port of the 16x8 register file and shares it between three requesters: ALU writeback, load unit, and debug/init port.
- After reset, and on demand, it sequences a zero-fill of every register, because the register file has no reset of its own.
- Sits between the execute/load stages and the register file's WriteEn/Waddr/DataIn inputs.

---
 rtl/regfile_write_arbiter.sv | 139 +++++++++++++
 tb/tb_regfile_write_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Write-port arbiter for the 16x8 register file: ALU, load and debug
// requesters share one port, plus a zero-fill sequence after reset.
module regfile_write_arbiter #(
  parameter int W            = 8,
  parameter int D            = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic         Clk,
  input  logic         ResetN,
  input  logic         AluReq,
  input  logic [D-1:0] AluAddr,
  input  logic [W-1:0] AluData,
  output logic         AluGnt,
  input  logic         LdReq,
  input  logic [D-1:0] LdAddr,
  input  logic [W-1:0] LdData,
  output logic         LdGnt,
  input  logic         DbgReq,
  input  logic [D-1:0] DbgAddr,
  input  logic [W-1:0] DbgData,
  output logic         DbgGnt,
  input  logic         SoftClear,
  output logic         Busy,
  output logic         ClearDone,
  output logic         WriteEn,
  output logic [D-1:0] Waddr,
  output logic [W-1:0] DataIn
);

  typedef enum logic [1:0] {
    RST_WAIT,
    CLEAR,
    RUN
  } state_t;

  localparam logic [D-1:0] LAST  = '1;
  localparam logic [7:0]   LIMIT = 8'(STARVE_LIMIT);

  state_t       state, state_nx;
  logic [D-1:0] cnt, cnt_nx;
  logic [7:0]   dbg_wait, dbg_wait_nx;
  logic         rr_alu, rr_alu_nx;
  logic         done_nx;
  logic         starve;

  // rr_alu: ALU holds the tie-break next; starts set so ALU wins first.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state     <= RST_WAIT;
      cnt       <= '0;
      dbg_wait  <= '0;
      rr_alu    <= 1'b1;
      ClearDone <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      dbg_wait  <= dbg_wait_nx;
      rr_alu    <= rr_alu_nx;
      ClearDone <= done_nx;
    end
  end

  assign starve = DbgReq && (dbg_wait >= LIMIT);

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    dbg_wait_nx = dbg_wait;
    rr_alu_nx   = rr_alu;
    done_nx     = 1'b0;
    Busy        = 1'b1;
    WriteEn     = 1'b0;
    Waddr       = '0;
    DataIn      = '0;
    AluGnt      = 1'b0;
    LdGnt       = 1'b0;
    DbgGnt      = 1'b0;
    unique case (state)
      RST_WAIT: begin
        state_nx = CLEAR;
        cnt_nx   = '0;
      end
      CLEAR: begin
        WriteEn = 1'b1;
        Waddr   = cnt;
        cnt_nx  = cnt + 1'b1;
        if (cnt == LAST) begin
          state_nx = RUN;
          done_nx  = 1'b1;
        end
      end
      RUN: begin
        Busy = 1'b0;
        if (SoftClear) begin
          state_nx = CLEAR;
          cnt_nx   = '0;
        end else begin
          priority case (1'b1)
            starve:           DbgGnt = 1'b1;
            AluReq && LdReq: begin
              AluGnt = rr_alu;
              LdGnt  = !rr_alu;
            end
            AluReq:           AluGnt = 1'b1;
            LdReq:            LdGnt  = 1'b1;
            DbgReq:           DbgGnt = 1'b1;
            default: ;
          endcase
        end
        if (AluGnt) rr_alu_nx = 1'b0;
        if (LdGnt)  rr_alu_nx = 1'b1;
        if (DbgReq && !DbgGnt) begin
          if (dbg_wait != 8'hFF)
            dbg_wait_nx = dbg_wait + 8'd1;
        end else begin
          dbg_wait_nx = '0;
        end
        WriteEn = AluGnt | LdGnt | DbgGnt;
        priority case (1'b1)
          AluGnt: begin
            Waddr  = AluAddr;
            DataIn = AluData;
          end
          LdGnt: begin
            Waddr  = LdAddr;
            DataIn = LdData;
          end
          DbgGnt: begin
            Waddr  = DbgAddr;
            DataIn = DbgData;
          end
          default: ;
        endcase
      end
      default: state_nx = RST_WAIT;
    endcase
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: per-cycle model compare plus
// directed scenarios with hand-computed expectations.
module tb_regfile_write_arbiter;

  logic       Clk = 0;
  logic       ResetN = 0;
  logic       AluReq = 0, LdReq = 0, DbgReq = 0;
  logic [3:0] AluAddr = 0, LdAddr = 0, DbgAddr = 0;
  logic [7:0] AluData = 0, LdData = 0, DbgData = 0;
  logic       SoftClear = 0;
  logic       AluGnt, LdGnt, DbgGnt;
  logic       Busy, ClearDone, WriteEn;
  logic [3:0] Waddr;
  logic [7:0] DataIn;

  int checks = 0;
  int failures = 0;

  regfile_write_arbiter #(.W(8), .D(4), .STARVE_LIMIT(8)) dut (
    .Clk(Clk), .ResetN(ResetN),
    .AluReq(AluReq), .AluAddr(AluAddr),
    .AluData(AluData), .AluGnt(AluGnt),
    .LdReq(LdReq), .LdAddr(LdAddr),
    .LdData(LdData), .LdGnt(LdGnt),
    .DbgReq(DbgReq), .DbgAddr(DbgAddr),
    .DbgData(DbgData), .DbgGnt(DbgGnt),
    .SoftClear(SoftClear), .Busy(Busy),
    .ClearDone(ClearDone), .WriteEn(WriteEn),
    .Waddr(Waddr), .DataIn(DataIn)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h",
               nm, act, req);
    end
  endtask

  // Model: phase 0 = waiting after reset, 1 = clearing, 2 = running
  int   m_phase, m_idx, m_wait;
  bit   m_alu_next, m_done;

  // packed {busy, done, we, waddr[4], data[8], dbg, ld, alu}
  function automatic logic [17:0] model_out();
    logic [2:0] g;
    logic [3:0] a;
    logic [7:0] d;
    g = 3'b000; a = 0; d = 0;
    if (m_phase == 0)
      return {1'b1, m_done, 1'b0, 4'h0, 8'h0, 3'b000};
    if (m_phase == 1)
      return {1'b1, m_done, 1'b1, 4'(m_idx), 8'h0, 3'b000};
    if (!SoftClear) begin
      if (DbgReq && m_wait >= 8)    g = 3'b100;
      else if (AluReq && LdReq)
        g = m_alu_next ? 3'b001 : 3'b010;
      else if (AluReq)              g = 3'b001;
      else if (LdReq)               g = 3'b010;
      else if (DbgReq)              g = 3'b100;
    end
    if (g[0]) begin a = AluAddr; d = AluData; end
    if (g[1]) begin a = LdAddr;  d = LdData;  end
    if (g[2]) begin a = DbgAddr; d = DbgData; end
    return {1'b0, m_done, |g, a, d, g};
  endfunction

  always @(posedge Clk or negedge ResetN) begin
    logic [17:0] e;
    if (!ResetN) begin
      m_phase <= 0; m_idx <= 0; m_wait <= 0;
      m_alu_next <= 1; m_done <= 0;
    end else begin
      e = model_out();
      m_done <= (m_phase == 1 && m_idx == 15);
      if (m_phase == 0) begin
        m_phase <= 1; m_idx <= 0;
      end else if (m_phase == 1) begin
        if (m_idx == 15) begin
          m_phase <= 2; m_idx <= 0;
        end else m_idx <= m_idx + 1;
      end else begin
        if (SoftClear) begin
          m_phase <= 1; m_idx <= 0;
        end
        if (e[0]) m_alu_next <= 0;
        if (e[1]) m_alu_next <= 1;
        if (DbgReq && !e[2])
          m_wait <= (m_wait < 255) ? m_wait + 1 : 255;
        else m_wait <= 0;
      end
    end
  end

  always @(negedge Clk) begin
    chk("cycle_outputs",
        {14'h0, Busy, ClearDone, WriteEn, Waddr, DataIn,
         DbgGnt, LdGnt, AluGnt},
        {14'h0, model_out()});
  end

  // Register file model fed by the DUT write port
  logic [7:0] mem [16];
  logic       p_we;
  logic [3:0] p_wa;
  logic [7:0] p_wd;
  always @(negedge Clk) begin
    p_we <= WriteEn; p_wa <= Waddr; p_wd <= DataIn;
  end
  always @(posedge Clk)
    if (ResetN && p_we) mem[p_wa] <= p_wd;

  task automatic cyc();
    @(posedge Clk); #1;
  endtask

  initial begin
    int busy_n, dbg_at, zeros;
    logic [5:0] seq;
    bit ok, hit;
    for (int i = 0; i < 16; i++) mem[i] = 8'hEE;

    // reset held
    repeat (2) @(negedge Clk);
    chk("reset_busy", Busy, 1);
    chk("reset_we", WriteEn, 0);
    chk("reset_done", ClearDone, 0);

    // release and count busy cycles
    @(negedge Clk);
    ResetN = 1;
    busy_n = 0;
    for (int i = 0; i < 40; i++) begin
      if (!Busy) break;
      busy_n++;
      @(negedge Clk);
    end
    chk("init_busy_cycles", busy_n, 17);
    chk("init_clear_done", ClearDone, 1);
    zeros = 0;
    for (int i = 0; i < 16; i++)
      if (mem[i] == 0) zeros++;
    chk("init_all_zero", zeros, 16);

    // ALU/LD round robin
    cyc();
    AluReq = 1; AluAddr = 3; AluData = 8'h11;
    LdReq = 1; LdAddr = 11; LdData = 8'h22;
    for (int i = 0; i < 6; i++) begin
      @(negedge Clk);
      seq[i] = AluGnt && !LdGnt;
      cyc();
    end
    AluReq = 0; LdReq = 0;
    chk("rr_alternate", seq, 6'b010101);
    chk("rr_r3", mem[3], 8'h11);
    chk("rr_r11", mem[11], 8'h22);

    // debug starvation
    AluReq = 1; LdReq = 1;
    DbgReq = 1; DbgAddr = 15; DbgData = 8'h5A;
    dbg_at = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge Clk);
      if (DbgGnt && dbg_at == 0) dbg_at = i;
      cyc();
      if (dbg_at != 0) begin
        DbgReq = 0;
        break;
      end
    end
    chk("starve_grant_cycle", dbg_at, 9);
    @(negedge Clk);
    chk("starve_resume_alu", {AluGnt, LdGnt}, 2'b10);
    cyc();
    AluReq = 0; LdReq = 0;
    chk("starve_r15", mem[15], 8'h5A);

    // soft clear
    LdReq = 1; LdAddr = 12; LdData = 8'h7F;
    cyc();
    LdReq = 0;
    chk("sc_r12_written", mem[12], 8'h7F);
    AluReq = 1; SoftClear = 1;
    @(negedge Clk);
    chk("sc_no_grant", {AluGnt, WriteEn}, 2'b00);
    cyc();
    SoftClear = 0;
    busy_n = 0;
    ok = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clk);
      if (!Busy) break;
      busy_n++;
      if (AluGnt) ok = 0;
    end
    chk("sc_clear_cycles", busy_n, 16);
    chk("sc_no_alu_in_clear", ok, 1);
    chk("sc_done_alu_gnt", {ClearDone, AluGnt}, 2'b11);
    chk("sc_r12_zero", mem[12], 8'h00);
    cyc();
    AluReq = 0;

    // async reset mid-clear at counter 7
    SoftClear = 1;
    cyc();
    SoftClear = 0;
    hit = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge Clk);
      if (Busy && WriteEn && Waddr == 7) begin
        hit = 1;
        break;
      end
    end
    chk("ar_reached_7", hit, 1);
    #2 ResetN = 0;
    #1;
    chk("ar_async_out", {Busy, WriteEn, Waddr, DataIn},
        {1'b1, 1'b0, 4'h0, 8'h0});
    @(negedge Clk);
    ResetN = 1;
    chk("ar_rst_wait_we", WriteEn, 0);
    ok = 1;
    for (int i = 0; i < 16; i++) begin
      @(negedge Clk);
      if (!(Busy && WriteEn && Waddr == 4'(i)))
        ok = 0;
    end
    chk("ar_full_reclear", ok, 1);
    @(negedge Clk);
    chk("ar_done", {Busy, ClearDone}, 2'b01);

    // lone debug request
    cyc();
    DbgReq = 1; DbgAddr = 9; DbgData = 8'h33;
    @(negedge Clk);
    chk("dbg_single",
        {DbgGnt, WriteEn, Waddr, DataIn},
        {1'b1, 1'b1, 4'd9, 8'h33});
    cyc();
    DbgReq = 0;
    chk("dbg_wait_zero", dut.dbg_wait, 0);
    chk("dbg_r9", mem[9], 8'h33);
    repeat (2) @(negedge Clk);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
